// File: rtl/lab3_bcd_counter.sv
// Two-digit BCD up-counter with run/clear control and a captured, clamped terminal count.
// While run is low the count clears and the terminal count is captured; while high it counts and saturates.
module lab3_bcd_counter #(
  parameter int MAX_LIMIT = 99
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       run,
  input  logic [6:0] max_count,
  output logic [3:0] digit1,
  output logic [3:0] digit2
);

  localparam logic [6:0] LIMIT = 7'(MAX_LIMIT);

  logic [6:0] max_clamped;
  logic [7:0] max_bcd_next;
  logic [3:0] max_ones;
  logic [3:0] max_tens;
  logic       at_max;
  logic [3:0] ones_next;
  logic [3:0] tens_next;

  // Compare/subtract conversion: pick the largest multiple of ten not exceeding v.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 9; i >= 1; i--) begin
      if (tens == 4'd0 && v >= 7'(i * 10)) begin
        tens = 4'(i);
        rem  = v - 7'(i * 10);
      end
    end
    return {tens, rem[3:0]};
  endfunction

  always_comb begin
    max_clamped = max_count;
    if (max_count > LIMIT) max_clamped = LIMIT;
  end

  assign max_bcd_next = bin_to_bcd(max_clamped);
  assign at_max       = (digit2 == max_tens) && (digit1 == max_ones);

  always_comb begin
    ones_next = digit1 + 4'd1;
    tens_next = digit2;
    if (digit1 == 4'd9) begin
      ones_next = 4'd0;
      tens_next = digit2 + 4'd1;
    end
  end

  // Registered count and captured terminal count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      digit1   <= 4'd0;
      digit2   <= 4'd0;
      max_ones <= 4'd0;
      max_tens <= 4'd0;
    end else if (!run) begin
      digit1   <= 4'd0;
      digit2   <= 4'd0;
      max_tens <= max_bcd_next[7:4];
      max_ones <= max_bcd_next[3:0];
    end else if (!at_max) begin
      digit1 <= ones_next;
      digit2 <= tens_next;
    end
  end

endmodule

// File: tb/tb_lab3_bcd_counter.sv
// Randomized and directed bench for lab3_bcd_counter against an integer reference model.
module tb_lab3_bcd_counter;

  logic       CLK;
  logic       RST_N;
  logic       run;
  logic [6:0] max_count;
  logic [3:0] digit1;
  logic [3:0] digit2;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: count and captured max as plain integers
  int m_cnt = 0;
  int m_max = 0;

  lab3_bcd_counter #(.MAX_LIMIT(99)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .run      (run),
    .max_count(max_count),
    .digit1   (digit1),
    .digit2   (digit2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] exp_bcd();
    return {4'(m_cnt / 10), 4'(m_cnt % 10)};
  endfunction

  function automatic int got_value();
    return int'(digit2) * 10 + int'(digit1);
  endfunction

  task automatic step(input logic r, input int mc);
    @(negedge CLK);
    run       = r;
    max_count = 7'(mc);
    @(posedge CLK);
    if (!RST_N) begin
      m_cnt = 0;
      m_max = 0;
    end else if (!r) begin
      m_cnt = 0;
      m_max = (mc > 99) ? 99 : mc;
    end else if (m_cnt < m_max) begin
      m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; run = 1'b0; max_count = 7'd0;
    #2;
    n_checks++;
    if ({digit2, digit1} !== 8'h00) $display("FAIL reset_initial got %h expected 00", {digit2, digit1});
    else n_pass++;
    @(negedge CLK); RST_N = 1'b1;
    step(0, 50);
    for (int i = 0; i < 6; i++) step(1, 50);
    n_checks++;
    if ({digit2, digit1} !== exp_bcd()) $display("FAIL reset_precount got %h expected %h", {digit2, digit1}, exp_bcd());
    else n_pass++;
    // asynchronous assertion mid-cycle, away from any edge
    @(posedge CLK); #3;
    RST_N = 1'b0;
    #1;
    m_cnt = 0; m_max = 0;
    n_checks++;
    if ({digit2, digit1} !== 8'h00) $display("FAIL reset_async got %h expected 00", {digit2, digit1});
    else n_pass++;
    @(negedge CLK); RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1, 40);
      n_checks++;
      if ({digit2, digit1} !== 8'h00) $display("FAIL reset_hold cycle %0d got %h expected 00", i, {digit2, digit1});
      else n_pass++;
    end
    step(0, 9);
    for (int i = 0; i < 12; i++) step(1, 9);
    n_checks++;
    if ({digit2, digit1} !== 8'h09) $display("FAIL reset_recapture got %h expected 09", {digit2, digit1});
    else n_pass++;
  endtask

  task automatic test_count_73();
    step(0, 73);
    for (int i = 1; i <= 85; i++) begin
      step(1, (i >= 75) ? 15 : 73);
      n_checks++;
      if ({digit2, digit1} !== exp_bcd() || got_value() != ((i < 73) ? i : 73))
        $display("FAIL count73 edge %0d got %h expected %h", i, {digit2, digit1}, exp_bcd());
      else n_pass++;
    end
  endtask

  task automatic test_restart_15();
    step(0, 15);
    n_checks++;
    if ({digit2, digit1} !== 8'h00) $display("FAIL restart_clear got %h expected 00", {digit2, digit1});
    else n_pass++;
    for (int i = 1; i <= 35; i++) begin
      step(1, (i > 25) ? 118 : 15);
      n_checks++;
      if ({digit2, digit1} !== exp_bcd() || got_value() != ((i < 15) ? i : 15))
        $display("FAIL restart15 edge %0d got %h expected %h", i, {digit2, digit1}, exp_bcd());
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    step(0, 118);
    for (int i = 1; i <= 106; i++) begin
      step(1, 118);
      n_checks++;
      if ({digit2, digit1} !== exp_bcd() || got_value() != ((i < 99) ? i : 99))
        $display("FAIL saturate edge %0d got %h expected %h", i, {digit2, digit1}, exp_bcd());
      else n_pass++;
    end
  endtask

  task automatic test_zero_max();
    step(0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 0);
      n_checks++;
      if ({digit2, digit1} !== 8'h00) $display("FAIL zero_max edge %0d got %h expected 00", i, {digit2, digit1});
      else n_pass++;
    end
  endtask

  task automatic test_carry();
    step(0, 20);
    for (int i = 1; i <= 25; i++) begin
      step(1, 20);
      n_checks++;
      if ({digit2, digit1} !== exp_bcd() || digit1 > 4'd9 || digit2 > 4'd9)
        $display("FAIL carry edge %0d got %h expected %h", i, {digit2, digit1}, exp_bcd());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic r;
    int   mc;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 15) != 0);
      mc = $urandom_range(0, 127);
      step(r, mc);
      n_checks++;
      if ({digit2, digit1} !== exp_bcd() || digit1 > 4'd9 || digit2 > 4'd9 || got_value() > m_max)
        $display("FAIL random step %0d got %h expected %h", i, {digit2, digit1}, exp_bcd());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_count_73();
    test_restart_15();
    test_saturate();
    test_zero_max();
    test_carry();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lab3_bcd_counter.md
Name: lab3_bcd_counter

Overview:
- Two-digit BCD up-counter (00..99) with a run/clear control and a programmable terminal count.
- While `run` is low, the counter clears and captures the terminal count from a 7-bit binary input.
- While `run` is high, it counts up one per clock and stops at the captured terminal count.
- Feeds a two-digit 7-segment display path (decoding done downstream).

Parameters:
- MAX_LIMIT, 99, ceiling applied to the captured terminal count (must be ≤99).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- run  input  1  1 = count enabled; 0 = clear counter and capture max_count.
- max_count  input  7  binary terminal count (0..127).
- digit1  output  4  BCD ones digit of current count (0..9).
- digit2  output  4  BCD tens digit of current count (0..9).

Behaviour:
- Reset (RST_N low, asynchronous, takes effect immediately):
  - digit1 = 0, digit2 = 0.
  - Captured max register = 0.
  - Reset dominates run.
- Capture/clear state (run sampled 0 at a rising edge):
  - Count loads 00.
  - Max register loads min(max_count, MAX_LIMIT), converted binary→BCD (tens = value/10, ones = value%10). Use any synthesizable conversion: double-dabble or compare/subtract.
  - Capture repeats every edge while run = 0, so the last value before run rises is the one used.
- Count state (run sampled 1 at a rising edge):
  - Max register holds; max_count changes are ignored until run returns to 0.
  - If count ≠ captured max: BCD increment. Ones 9→0 with carry into tens; tens increments on carry.
  - If count = captured max: hold (saturate; no wrap).
  - Captured max 0 → count stays 00.
- Latency:
  - The first rising edge with run = 1 produces 01 (when max ≥1).
  - Count N reached N edges after run rises.
- run falling mid-count: count is 00 after the next rising edge, and the new max is captured on that same edge.
- Outputs are registered. No combinational path from inputs to digit1/digit2.
- Invariants: each digit is always 0..9; count never exceeds the captured max; count never exceeds 99.
- max_count values 100..127 saturate to 99.

Test Plan:
- Reset then hold: RST_N low mid-count → digit2:digit1 = 0:0 immediately; max register 0; with run = 1 after release, count stays 00 until run cycles 0→1 with new max.
- Count to 73 with mid-run change:
  - Stimulus: run = 0, max_count = 73; raise run; at cycle ~75 set max_count = 15.
  - Required: count reaches 7:3 exactly 73 edges after run rises, then holds 7:3.
  - Required: the max_count change has no effect.
- Restart to 15 with mid-run change:
  - Stimulus: drop run → 00 next edge; raise run; 25 cycles later set max_count = 118.
  - Required: counts 1..15 in BCD (…0:9, 1:0, …) and holds 1:5; the change to 118 is ignored.
- Saturation above 99: run 0 then 1 with max_count = 118 captured → counts to 9:9 after 99 edges, holds, no wrap to 00.
- max_count = 0 captured, run = 1 for 20 cycles → output remains 0:0.
- Digit carry check: max_count = 20 → sequence …0:8, 0:9, 1:0, …, 1:9, 2:0, then hold; digits never show values A–F.
